adc_avg_filter: RTL and testbench

Per-channel oversampling averager placed directly downstream of the MAX10 ADC IP response stream. It consumes `ADC_R_*` beats, accumulates 2^AVG_LOG2 samples per channel, and publishes the truncated mean per channel. The result appears as a 32-bit readout word on `RADDR`/`RDATA`, which the board top drives onto the seven-segment display. It replaces raw single-sample readout wherever noise on the display is unacceptable.

---
 rtl/adc_avg_filter_if.sv | 22 ++
 rtl/adc_avg_filter.sv | 159 +++++++++++++++
 tb/tb_adc_avg_filter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_avg_filter_if.sv
// -----------------------------------------------------------------------------
// adc_avg_filter_if
// Response-beat bus from the MAX10 ADC IP into the averaging filter.
// There is no backpressure: every beat with ADC_R_Valid high is consumed.
//
// Signals
//   ADC_R_Valid    beat valid
//   ADC_R_Channel  channel of the beat (5 bits)
//   ADC_R_Data     raw 12-bit sample
//
// Modports
//   master  beat producer (ADC IP side)
//   slave   beat consumer (adc_avg_filter)
// -----------------------------------------------------------------------------
interface adc_avg_filter_if;
  logic        ADC_R_Valid;
  logic [4:0]  ADC_R_Channel;
  logic [11:0] ADC_R_Data;

  modport master (output ADC_R_Valid, output ADC_R_Channel, output ADC_R_Data);
  modport slave  (input  ADC_R_Valid, input  ADC_R_Channel, input  ADC_R_Data);
endinterface

// File: rtl/adc_avg_filter.sv
// -----------------------------------------------------------------------------
// adc_avg_filter
// Per-channel oversampling averager for the MAX10 ADC response stream.
// Each channel accumulates 2^AVG_LOG2 samples and publishes the truncated
// mean; the selected channel is presented as a registered 32-bit readout word.
//
// Parameters
//   CHANNELS  number of tracked channels, 1..32
//   AVG_LOG2  log2 of samples per average, 0..6
//
// Ports
//   CLK         system clock (same as ADC IP clock_clk)
//   RESETn      asynchronous active-low reset
//   adc_r       ADC response beats (adc_avg_filter_if.slave)
//   CLR         synchronous clear of all channel state, active-high
//   RADDR       readout channel select
//   RDATA       registered readout word:
//                 [11:0] latest average, [27:16] peak sample,
//                 [31] at least one average completed, other bits 0
//   AVG_STROBE  one-cycle pulse when any channel completes an average
//
// Build option
//   ADC_AVG_PEAK_EN  when defined, each channel also tracks its peak sample,
//                    shown in RDATA[27:16]; otherwise those bits read 0.
// -----------------------------------------------------------------------------
module adc_avg_filter #(
  parameter int CHANNELS = 9,
  parameter int AVG_LOG2 = 4
) (
  input  logic              CLK,
  input  logic              RESETn,
  adc_avg_filter_if.slave   adc_r,
  input  logic              CLR,
  input  logic [4:0]        RADDR,
  output logic [31:0]       RDATA,
  output logic              AVG_STROBE
);

  localparam int ACC_W = 12 + AVG_LOG2;
  // With AVG_LOG2 = 0 the window counter is a single bit held at zero, so
  // every beat is both the first and the last sample of its window.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  // ---------------------------------------------------------------------------
  // Stage 1: capture. Out-of-range channels are captured as invalid.
  // ---------------------------------------------------------------------------
  logic        s1_valid;
  logic [4:0]  s1_ch;
  logic [11:0] s1_data;
  logic        ch_in_range;

  assign ch_in_range = (int'(adc_r.ADC_R_Channel) < CHANNELS);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= adc_r.ADC_R_Valid && ch_in_range && !CLR;
      s1_ch    <= adc_r.ADC_R_Channel;
      s1_data  <= adc_r.ADC_R_Data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: per-channel accumulate. Each channel owns its state in flops and
  // updates in a single cycle, so back-to-back beats on one channel are safe.
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0]        win_done;
  logic [CHANNELS-1:0][31:0]  ch_word;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [11:0]      res_q;
    logic             vld_q;
    logic             hit;
    logic             last;
    logic [ACC_W-1:0] sum;

    assign hit  = s1_valid && (s1_ch == 5'(c));
    assign last = (cnt_q == CNT_LAST);
    // First sample of a window reloads instead of adding to stale state.
    assign sum  = (cnt_q == '0) ? ACC_W'(s1_data) : acc_q + ACC_W'(s1_data);
    assign win_done[c] = hit && last;

    // NOTE: the per-channel arrays are reset too: VALID and the average must
    // read 0 after reset, and a partial window must not survive it.
    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        acc_q <= '0;
        cnt_q <= '0;
        res_q <= '0;
        vld_q <= 1'b0;
      end else if (CLR) begin
        acc_q <= '0;
        cnt_q <= '0;
        res_q <= '0;
        vld_q <= 1'b0;
      end else if (hit) begin
        acc_q <= sum;
        cnt_q <= last ? '0 : cnt_q + 1'b1;
        if (last) begin
          res_q <= 12'(sum >> AVG_LOG2);
          vld_q <= 1'b1;
        end
      end
    end

`ifdef ADC_AVG_PEAK_EN
    logic [11:0] peak_q;

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        peak_q <= '0;
      end else if (CLR) begin
        peak_q <= '0;
      end else if (hit && (s1_data > peak_q)) begin
        peak_q <= s1_data;
      end
    end

    assign ch_word[c] = {vld_q, 3'b000, peak_q, 4'b0000, res_q};
`else
    assign ch_word[c] = {vld_q, 3'b000, 12'h000, 4'b0000, res_q};
`endif
  end

  // ---------------------------------------------------------------------------
  // Strobe and readout
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;

  // NOTE: rd_word gets a default before the loop so no path leaves it
  // unassigned; RADDR values with no matching channel read 0.
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (RADDR == 5'(c)) rd_word = ch_word[c];
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      AVG_STROBE <= 1'b0;
      RDATA      <= '0;
    end else begin
      AVG_STROBE <= (|win_done) && !CLR;
      // Readout samples post-update state one edge later, so a cleared
      // channel shows as 0 on the edge after CLR.
      RDATA      <= rd_word;
    end
  end

endmodule

// File: tb/tb_adc_avg_filter.sv
// -----------------------------------------------------------------------------
// tb_adc_avg_filter
// Scoreboard bench for adc_avg_filter. Two instances: the default build
// (CHANNELS = 9, AVG_LOG2 = 4) and a single-sample build (AVG_LOG2 = 0).
// Stimulus pushes the expected readout word for every window it completes;
// a monitor per instance pops one entry on each AVG_STROBE and compares RDATA
// on the following cycle. Reset, clear and out-of-range cases are checked
// directly from the stimulus process.
// -----------------------------------------------------------------------------
module tb_adc_avg_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, clr0;
  logic [4:0]  raddr, raddr0;
  logic [31:0] rdata, rdata0;
  logic        strobe, strobe0;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp0_q[$];

  always #5 clk = ~clk;

  adc_avg_filter_if bus ();
  adc_avg_filter_if bus0 ();

  adc_avg_filter #(.CHANNELS(9), .AVG_LOG2(4)) dut (
    .CLK        (clk),
    .RESETn     (rst_n),
    .adc_r      (bus),
    .CLR        (clr),
    .RADDR      (raddr),
    .RDATA      (rdata),
    .AVG_STROBE (strobe)
  );

  adc_avg_filter #(.CHANNELS(9), .AVG_LOG2(0)) dut0 (
    .CLK        (clk),
    .RESETn     (rst_n),
    .adc_r      (bus0),
    .CLR        (clr0),
    .RADDR      (raddr0),
    .RDATA      (rdata0),
    .AVG_STROBE (strobe0)
  );

  // Expected readout word; the peak field is only populated in the peak build.
  function automatic logic [31:0] w(input logic v, input logic [11:0] pk,
                                    input logic [11:0] avg);
`ifdef ADC_AVG_PEAK_EN
    return {v, 3'b000, pk, 4'b0000, avg};
`else
    return {v, 3'b000, 12'h000, 4'b0000, avg};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  logic        pend  = 1'b0;
  logic        pend0 = 1'b0;
  logic [31:0] pend_exp, pend0_exp;

  always @(posedge clk) begin
    #1;
    if (pend) begin
      check("avg_rdata", rdata, pend_exp);
      pend = 1'b0;
    end
    if (strobe) begin
      if (exp_q.size() == 0) check("unexpected_strobe", {31'b0, strobe}, 32'h0);
      else begin
        pend_exp = exp_q.pop_front();
        pend     = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (pend0) begin
      check("l0_rdata", rdata0, pend0_exp);
      pend0 = 1'b0;
    end
    if (strobe0) begin
      if (exp0_q.size() == 0) check("l0_unexpected_strobe", {31'b0, strobe0}, 32'h0);
      else begin
        pend0_exp = exp0_q.pop_front();
        pend0     = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic beat(input logic [4:0] ch, input logic [11:0] d);
    @(negedge clk);
    bus.ADC_R_Valid   = 1'b1;
    bus.ADC_R_Channel = ch;
    bus.ADC_R_Data    = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.ADC_R_Valid = 1'b0;
    end
  endtask

  task automatic clear_all();
    @(negedge clk);
    bus.ADC_R_Valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    idle(2);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    clr = 1'b0; clr0 = 1'b0;
    raddr = '0; raddr0 = '0;
    bus.ADC_R_Valid = 1'b0;  bus.ADC_R_Channel = '0;  bus.ADC_R_Data = '0;
    bus0.ADC_R_Valid = 1'b0; bus0.ADC_R_Channel = '0; bus0.ADC_R_Data = '0;

    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_strobe", {31'b0, strobe}, 32'h0);
    check("reset_rdata_l0", rdata0, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Averaging: 0x100..0x10F on ch 3 -> mean 0x107, peak 0x10F.
    raddr = 5'd3;
    exp_q.push_back(w(1'b1, 12'h10F, 12'h107));
    for (int i = 0; i < 16; i++) beat(5'd3, 12'h100 + 12'(i));
    idle(4);
    check("avg_hold", rdata, w(1'b1, 12'h10F, 12'h107));
    clear_all();
    check("clear_rdata", rdata, 32'h0);

    // Partial window on ch 0, full window on ch 1, then finish ch 0.
    raddr = 5'd0;
    for (int i = 0; i < 15; i++) beat(5'd0, 12'hFFF);
    idle(4);
    check("partial_ch0", rdata, w(1'b0, 12'hFFF, 12'h000));
    raddr = 5'd1;
    exp_q.push_back(w(1'b1, 12'h010, 12'h010));
    for (int i = 0; i < 16; i++) beat(5'd1, 12'h010);
    idle(4);
    raddr = 5'd0;
    exp_q.push_back(w(1'b1, 12'hFFF, 12'hFFF));
    beat(5'd0, 12'hFFF);
    idle(4);
    raddr = 5'd1;
    idle(2);
    check("ch1_after_ch0", rdata, w(1'b1, 12'h010, 12'h010));

    // Out-of-range channel: a full window on ch 20 must be ignored.
    clear_all();
    for (int i = 0; i < 16; i++) beat(5'd20, 12'hABC);
    idle(4);
    raddr = 5'd20;
    idle(2);
    check("raddr_oor", rdata, 32'h0);
    raddr = 5'd4;
    idle(2);
    check("ch4_untouched", rdata, 32'h0);

    // CLR in the same cycle as the 16th beat: no strobe, channel cleared.
    clear_all();
    raddr = 5'd3;
    for (int i = 0; i < 15; i++) beat(5'd3, 12'h200);
    @(negedge clk);
    bus.ADC_R_Valid = 1'b1; bus.ADC_R_Channel = 5'd3; bus.ADC_R_Data = 12'h200;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    bus.ADC_R_Valid = 1'b0;
    idle(4);
    check("clr_collision", rdata, 32'h0);
    exp_q.push_back(w(1'b1, 12'h30F, 12'h307));
    for (int i = 0; i < 16; i++) beat(5'd3, 12'h300 + 12'(i));
    idle(4);

    // Async reset mid-window on ch 5.
    raddr = 5'd5;
    for (int i = 0; i < 8; i++) beat(5'd5, 12'hFFF);
    idle(3);
    check("pre_reset", rdata, w(1'b0, 12'hFFF, 12'h000));
    #2 rst_n = 1'b0;
    #1 check("reset_async", rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // 0x20..0x2F -> sum 0x278 -> mean 0x027, peak 0x02F.
    exp_q.push_back(w(1'b1, 12'h02F, 12'h027));
    for (int i = 0; i < 16; i++) beat(5'd5, 12'h020 + 12'(i));
    idle(4);

    // AVG_LOG2 = 0 build: back-to-back beats on ch 2.
    raddr0 = 5'd2;
    exp0_q.push_back(w(1'b1, 12'h123, 12'h123));
    exp0_q.push_back(w(1'b1, 12'h456, 12'h456));
    @(negedge clk);
    bus0.ADC_R_Valid = 1'b1; bus0.ADC_R_Channel = 5'd2; bus0.ADC_R_Data = 12'h123;
    @(negedge clk);
    bus0.ADC_R_Data = 12'h456;
    @(negedge clk);
    bus0.ADC_R_Valid = 1'b0;
    repeat (4) @(negedge clk);
    check("l0_final", rdata0, w(1'b1, 12'h456, 12'h456));

    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("exp0_q_drained", 32'(exp0_q.size()), 32'h0);
    check("pending_done", {30'b0, pend, pend0}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
